// File: rtl/spi_reg_burst.sv
// SPI mode-0 slave to register bridge with burst auto-increment and multi-byte words.
// Optional: define SPI_REG_BURST_STATUS_EN to shift the status byte out on MISO during the command byte.
module spi_reg_burst #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_data_o_dv,
  output logic              reg_rd,
  input  logic [7:0]        status,
  output logic              frame_active
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WAIT_CS
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_p1, sck_p1;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic [2:0]             fill_cnt;
  logic                   sync_ok;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_sr;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] tx_sr;
  logic              rw_q, burst_q;
  logic              miso_q;
  logic              wr_vld_p0, rd_vld_p0;
  logic              start_frame, cmd_done, word_done, abort, rise_ok;
  logic              status_bit_start, status_bit_next;

  // Stage p0: synchronisers and edge detection on the raw SPI pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_p1     <= 1'b1;
      sck_p1    <= 1'b0;
      fill_cnt  <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_p1     <= cs_s;
      sck_p1    <= sck_s;
      if (!sync_ok) fill_cnt <= fill_cnt + 3'd1;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  // Edges are trusted only once the chain holds real pin values, so a cs held low through reset is not seen as a fall
  assign sync_ok  = (fill_cnt == 3'(SYNC_STAGES + 1));
  assign cs_fall  = cs_p1 & ~cs_s;
  assign cs_rise  = ~cs_p1 & cs_s;
  assign sck_rise = ~sck_p1 & sck_s;
  assign sck_fall = sck_p1 & ~sck_s;

  assign shift_in     = {rx_sr, mosi_s};
  assign frame_active = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign rise_ok      = frame_active && sck_rise && !abort;
  assign spi_miso     = miso_q & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    cmd_done    = 1'b0;
    word_done   = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync_ok) begin
          if (cs_fall && ena) begin
            start_frame = 1'b1;
            state_d     = ST_CMD;
          end else if (!cs_s) begin
            state_d = ST_WAIT_CS;
          end
        end
      end
      ST_CMD: begin
        if (cs_rise || !ena) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (sck_rise && bit_cnt == CNT_W'(7)) begin
          cmd_done = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cs_rise || !ena) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (sck_rise && bit_cnt == CNT_W'(DATA_W - 1)) begin
          word_done = 1'b1;
        end
      end
      ST_WAIT_CS: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: frame decode, word assembly and register access strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      rx_sr         <= '0;
      rw_q          <= 1'b0;
      burst_q       <= 1'b0;
      reg_addr      <= '0;
      reg_data_o    <= '0;
      wr_vld_p0     <= 1'b0;
      reg_data_o_dv <= 1'b0;
      rd_vld_p0     <= 1'b0;
      reg_rd        <= 1'b0;
    end else begin
      wr_vld_p0     <= word_done & rw_q;
      reg_data_o_dv <= wr_vld_p0;
      rd_vld_p0     <= (cmd_done & ~shift_in[7]) | (word_done & ~rw_q);
      reg_rd        <= rd_vld_p0;

      if (start_frame || cmd_done || word_done) bit_cnt <= '0;
      else if (rise_ok)                         bit_cnt <= bit_cnt + CNT_W'(1);

      if (rise_ok) rx_sr <= shift_in[DATA_W-2:0];

      if (cmd_done) begin
        rw_q     <= shift_in[7];
        burst_q  <= shift_in[6];
        reg_addr <= shift_in[ADDR_W-1:0];
      end else if (burst_q && ((word_done && !rw_q) || (reg_data_o_dv && rw_q))) begin
        reg_addr <= reg_addr + ADDR_W'(1);
      end

      if (word_done && rw_q) reg_data_o <= shift_in;
    end
  end

  // Stage p2: read shift register and MISO driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr  <= '0;
      miso_q <= 1'b0;
    end else begin
      if (reg_rd)
        tx_sr <= reg_data_i;
      else if (state_q == ST_DATA && !rw_q && sck_fall && !abort)
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};

      if (start_frame)
        miso_q <= status_bit_start;
      else if (state_q == ST_CMD && !abort && sck_fall)
        miso_q <= status_bit_next;
      else if (state_q == ST_DATA && !abort && !rw_q && sck_fall)
        miso_q <= tx_sr[DATA_W-1];
      else if (!frame_active || abort || (state_q == ST_DATA && rw_q))
        miso_q <= 1'b0;
    end
  end

`ifdef SPI_REG_BURST_STATUS_EN
  logic [7:0] st_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st_sr <= '0;
    else if (start_frame)
      st_sr <= {status[6:0], 1'b0};
    else if (state_q == ST_CMD && sck_fall)
      st_sr <= {st_sr[6:0], 1'b0};
  end

  assign status_bit_start = status[7];
  assign status_bit_next  = st_sr[7];
`else
  logic status_unused;
  assign status_unused    = ^status;
  assign status_bit_start = 1'b0;
  assign status_bit_next  = 1'b0;
`endif

endmodule
